// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer.
// The main entry drives the outputs and the skid entry absorbs the beat that
// arrives while the downstream stalls. This lets in_ready depend only on
// registered state and freeze, so no combinational path runs from out_ready
// to in_ready.
// Freeze holds everything and overrides flush. Flush empties the stage and
// zeroes every payload register. A bubble presents all-zero control, so an
// empty stage can never trigger a memory access or a register write.
module pipe_stage_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  freeze,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [1:0]            occupancy
);

    logic                  main_valid_r;
    logic [DATA_WIDTH-1:0] main_data_r;
    logic [CTRL_WIDTH-1:0] main_ctrl_r;
    logic                  skid_valid_r;
    logic [DATA_WIDTH-1:0] skid_data_r;
    logic [CTRL_WIDTH-1:0] skid_ctrl_r;

    logic                  main_valid_s;
    logic [DATA_WIDTH-1:0] main_data_s;
    logic [CTRL_WIDTH-1:0] main_ctrl_s;
    logic                  skid_valid_s;
    logic [DATA_WIDTH-1:0] skid_data_s;
    logic [CTRL_WIDTH-1:0] skid_ctrl_s;

    logic                  accept_s;
    logic                  pop_s;

    // The handshake outputs come from registered state and freeze only.
    assign in_ready  = ~skid_valid_r & ~freeze;
    assign out_valid = main_valid_r & ~freeze;
    assign out_data  = main_data_r;
    assign accept_s  = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign occupancy = {1'b0, main_valid_r} + {1'b0, skid_valid_r};

    // A bubble presents zero control, so it has no side effects downstream.
    always_comb begin
        out_ctrl = {CTRL_WIDTH{1'b0}};
        if (main_valid_r) begin
            out_ctrl = main_ctrl_r;
        end else begin
            out_ctrl = {CTRL_WIDTH{1'b0}};
        end
    end

    // Next-state selection: freeze, then flush, then refill main or fill skid.
    always_comb begin
        main_valid_s = main_valid_r;
        main_data_s  = main_data_r;
        main_ctrl_s  = main_ctrl_r;
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
        skid_ctrl_s  = skid_ctrl_r;
        if (freeze) begin
            main_valid_s = main_valid_r;
        end else if (flush) begin
            main_valid_s = 1'b0;
            main_data_s  = {DATA_WIDTH{1'b0}};
            main_ctrl_s  = {CTRL_WIDTH{1'b0}};
            skid_valid_s = 1'b0;
            skid_data_s  = {DATA_WIDTH{1'b0}};
            skid_ctrl_s  = {CTRL_WIDTH{1'b0}};
        end else if (pop_s | ~main_valid_r) begin
            if (skid_valid_r) begin
                // The skid beat is older, so it moves to main first.
                main_valid_s = 1'b1;
                main_data_s  = skid_data_r;
                main_ctrl_s  = skid_ctrl_r;
                skid_valid_s = 1'b0;
                if (accept_s) begin
                    skid_valid_s = 1'b1;
                    skid_data_s  = in_data;
                    skid_ctrl_s  = in_ctrl;
                end else begin
                    skid_valid_s = 1'b0;
                end
            end else if (accept_s) begin
                main_valid_s = 1'b1;
                main_data_s  = in_data;
                main_ctrl_s  = in_ctrl;
            end else begin
                main_valid_s = 1'b0;
            end
        end else begin
            // Main is stalled: a newly accepted beat waits in skid.
            if (accept_s) begin
                skid_valid_s = 1'b1;
                skid_data_s  = in_data;
                skid_ctrl_s  = in_ctrl;
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end
    end

    // Stage state register; reset empties the stage and zeroes every payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_r <= 1'b0;
            main_data_r  <= {DATA_WIDTH{1'b0}};
            main_ctrl_r  <= {CTRL_WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {DATA_WIDTH{1'b0}};
            skid_ctrl_r  <= {CTRL_WIDTH{1'b0}};
        end else begin
            main_valid_r <= main_valid_s;
            main_data_r  <= main_data_s;
            main_ctrl_r  <= main_ctrl_s;
            skid_valid_r <= skid_valid_s;
            skid_data_r  <= skid_data_s;
            skid_ctrl_r  <= skid_ctrl_s;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg.
// The reference model treats the stage as an ordered queue that holds at
// most two beats. A beat enters the queue when it is offered and the queue is
// not full. The head of the queue leaves when it is presented and taken.
// Flush and reset empty the queue, and freeze holds it unchanged.
// The monitor compares the DUT outputs at every falling edge with the values
// the queue predicts.
module tb_pipe_stage_reg;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          freeze = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    popped = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: update the queue using the state as it was before the edge.
    always @(posedge clk) begin : model
        int sz;
        sz = exp_q.size();
        if (rst && !freeze) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (sz > 0 && out_ready) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
                if (in_valid && sz < 2) exp_q.push_back({in_data, in_ctrl});
            end
        end
    end

    // Reset discards all held beats immediately.
    always @(negedge rst) exp_q.delete();

    // Monitor: compare the presented state against the queue head.
    always @(negedge clk) begin : monitor
        int sz;
        sz = exp_q.size();
        chk("occupancy", 64'(occupancy), 64'(sz));
        chk("in_ready", 64'(in_ready), 64'(sz < 2 && !freeze));
        chk("out_valid", 64'(out_valid), 64'(sz > 0 && !freeze));
        if (sz > 0) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0].d));
            chk("out_ctrl", 64'(out_ctrl), 64'(exp_q[0].c));
        end else begin
            chk("out_ctrl_bubble", 64'(out_ctrl), 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int p0;
        // Reset state
        #3;
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        step(); step();
        rst = 1'b1;
        step();

        // Stream 1,2,3 with the downstream always ready
        p0 = popped;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i + 8'h10);
            step();
            chk("stream_occ", 64'(occupancy), 64'd1);
        end
        in_valid = 1'b0;
        step(); step();
        chk("stream_popped", 64'(popped - p0), 64'd3);

        // Backpressure with A and B
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; in_ctrl = 8'hA1;
        step();
        in_data = 32'hB; in_ctrl = 8'hB1;
        step();
        in_valid = 1'b0;
        #1;
        chk("bp_occ", 64'(occupancy), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head", 64'(out_data), 64'hA);
        out_ready = 1'b1;
        step();
        #1;
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        chk("bp_second", 64'(out_data), 64'hB);
        step(); step();

        // Flush with two beats held while C is offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h01;
        step();
        in_data = 32'h22; in_ctrl = 8'h02;
        step();
        in_data = 32'hC; in_ctrl = 8'hCC; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_data_zero", 64'(out_data), 64'd0);
        out_ready = 1'b1;
        step(); step();

        // Freeze takes priority over flush
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hD; in_ctrl = 8'hDD;
        step();
        in_valid = 1'b1; in_data = 32'hEE; freeze = 1'b1; flush = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_occ", 64'(occupancy), 64'd1);
            chk("frz_out_valid", 64'(out_valid), 64'd0);
            chk("frz_data", 64'(out_data), 64'hD);
        end
        freeze = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("frz_release_valid", 64'(out_valid), 64'd1);
        chk("frz_release_data", 64'(out_data), 64'hD);
        step(); step();

        // Asynchronous reset while two beats are held
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h51; in_ctrl = 8'h51;
        step();
        in_data = 32'h52; in_ctrl = 8'h52;
        step();
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_occ", 64'(occupancy), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        step();
        rst = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hE; in_ctrl = 8'hE1;
        step();
        in_valid = 1'b0;
        #1;
        chk("arst_first_valid", 64'(out_valid), 64'd1);
        chk("arst_first_data", 64'(out_data), 64'hE);
        step(); step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 65);
            flush     = ($urandom_range(0, 99) < 3);
            freeze    = ($urandom_range(0, 99) < 8);
            in_data   = DW'($urandom);
            in_ctrl   = CW'($urandom);
            step();
        end

        // Drain
        flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        chk("drain_occ", 64'(occupancy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
